// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush and operand forwarding control for a 5-stage pipeline
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_re1,
    input  logic             id_re2,
    input  logic [4:0]       id_rd,
    input  logic             id_rf_we,
    input  logic             id_is_load,
    input  logic             ex_br_taken,
    output logic             stall_if,
    output logic             stall_id,
    output logic             flush_id,
    output logic             flush_ex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam logic [CNT_W-1:0] ONE = 1;
    logic             ex_v_q, ex_we_q, ex_ld_q, ex_v_d, ex_we_d, ex_ld_d;
    logic             mem_v_q, mem_we_q, mem_ld_q, mem_v_d, mem_we_d, mem_ld_d;
    logic             wb_v_q, wb_we_q, wb_ld_q, wb_v_d, wb_we_d, wb_ld_d;
    logic [4:0]       ex_rd_q, mem_rd_q, wb_rd_q, ex_rd_d, mem_rd_d, wb_rd_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, stall_cnt_d, flush_cnt_d;
    logic             e1, e2, m1, m2, w1, w2, load_use, stall;

    function automatic logic hit(input logic v, input logic we, input logic [4:0] rd,
                                 input logic [4:0] rs, input logic re, input logic iv);
        return v && we && rd != 5'd0 && rd == rs && re && iv;
    endfunction

    // hazard detection and per-operand forwarding select; a load in EX is never forwarded from EX
    always_comb begin
        e1       = hit(ex_v_q, ex_we_q, ex_rd_q, id_rs1, id_re1, id_valid);
        e2       = hit(ex_v_q, ex_we_q, ex_rd_q, id_rs2, id_re2, id_valid);
        m1       = hit(mem_v_q, mem_we_q, mem_rd_q, id_rs1, id_re1, id_valid);
        m2       = hit(mem_v_q, mem_we_q, mem_rd_q, id_rs2, id_re2, id_valid);
        w1       = hit(wb_v_q, wb_we_q, wb_rd_q, id_rs1, id_re1, id_valid);
        w2       = hit(wb_v_q, wb_we_q, wb_rd_q, id_rs2, id_re2, id_valid);
        load_use = ex_ld_q && (e1 || e2);
        stall    = load_use && !ex_br_taken;
        stall_if = stall;
        stall_id = stall;
        flush_id = ex_br_taken;
        flush_ex = stall || ex_br_taken;
        fwd_a    = (e1 && !ex_ld_q) ? 2'b01 : m1 ? 2'b10 : w1 ? 2'b11 : 2'b00;
        fwd_b    = (e2 && !ex_ld_q) ? 2'b01 : m2 ? 2'b10 : w2 ? 2'b11 : 2'b00;
        stall_cnt = stall_cnt_q;
        flush_cnt = flush_cnt_q;
    end

    // shadow pipeline advance and saturating performance counters
    always_comb begin
        ex_v_d      = id_valid && !flush_ex;
        ex_rd_d     = id_rd;
        ex_we_d     = id_rf_we;
        ex_ld_d     = id_is_load;
        mem_v_d     = ex_v_q;
        mem_rd_d    = ex_rd_q;
        mem_we_d    = ex_we_q;
        mem_ld_d    = ex_ld_q;
        wb_v_d      = mem_v_q;
        wb_rd_d     = mem_rd_q;
        wb_we_d     = mem_we_q;
        wb_ld_d     = mem_ld_q;
        stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + ONE : stall_cnt_q;
        flush_cnt_d = (ex_br_taken && flush_cnt_q != '1) ? flush_cnt_q + ONE : flush_cnt_q;
    end

    // state registers; reset clears every slot field and both counters
    always_ff @(posedge clk) begin
        if (rst) begin
            {ex_v_q, ex_rd_q, ex_we_q, ex_ld_q}     <= '0;
            {mem_v_q, mem_rd_q, mem_we_q, mem_ld_q} <= '0;
            {wb_v_q, wb_rd_q, wb_we_q, wb_ld_q}     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            {ex_v_q, ex_rd_q, ex_we_q, ex_ld_q}     <= {ex_v_d, ex_rd_d, ex_we_d, ex_ld_d};
            {mem_v_q, mem_rd_q, mem_we_q, mem_ld_q} <= {mem_v_d, mem_rd_d, mem_we_d, mem_ld_d};
            {wb_v_q, wb_rd_q, wb_we_q, wb_ld_q}     <= {wb_v_d, wb_rd_d, wb_we_d, wb_ld_d};
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench comparing hazard_ctrl against an instruction-history reference model
module tb_hazard_ctrl;
    localparam int W = 4;
    localparam int SAT = (1 << W) - 1;
    logic clk = 0, rst, id_valid, id_re1, id_re2, id_rf_we, id_is_load, ex_br_taken;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic stall_if, stall_id, flush_id, flush_ex;
    logic [1:0] fwd_a, fwd_b;
    logic [W-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.CNT_W(W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_re1(id_re1), .id_re2(id_re2), .id_rd(id_rd), .id_rf_we(id_rf_we),
        .id_is_load(id_is_load), .ex_br_taken(ex_br_taken), .stall_if(stall_if),
        .stall_id(stall_id), .flush_id(flush_id), .flush_ex(flush_ex), .fwd_a(fwd_a),
        .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {bit v; bit we; bit ld; int rd;} ins_t;
    typedef struct {bit chk; logic [1:0] fa; logic [1:0] fb; bit sif; bit sid; bit fid; bit fex; int sc; int fc;} exp_t;

    ins_t hist[3];
    exp_t sbq[$];
    int checks = 0, errors = 0, m_sc = 0, m_fc = 0;

    // youngest older instruction writing rs supplies the operand; a load still in EX only raises load-use
    function automatic void src(input bit v, input int rs, input bit re, output logic [1:0] f, output bit lu);
        bit found = 0;
        f = 2'b00;
        lu = 0;
        for (int a = 0; a < 3; a++)
            if (!found && v && re && rs != 0 && hist[a].v && hist[a].we && hist[a].rd == rs) begin
                if (a == 0 && hist[a].ld) lu = 1;
                else begin
                    f = 2'(a + 1);
                    found = 1;
                end
            end
    endfunction

    task automatic drive(input bit r, input bit v, input int rd, input int rs1, input int rs2,
                         input bit re1, input bit re2, input bit we, input bit ld, input bit br);
        exp_t e;
        bit l1, l2, st;
        rst = r; id_valid = v; id_rd = 5'(rd); id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
        id_re1 = re1; id_re2 = re2; id_rf_we = we; id_is_load = ld; ex_br_taken = br;
        src(v, rs1, re1, e.fa, l1);
        src(v, rs2, re2, e.fb, l2);
        st = (l1 || l2) && !br;
        e.chk = !r; e.sif = st; e.sid = st; e.fid = br; e.fex = st || br; e.sc = m_sc; e.fc = m_fc;
        sbq.push_back(e);
        if (r) begin
            for (int a = 0; a < 3; a++) hist[a] = '{0, 0, 0, 0};
            m_sc = 0;
            m_fc = 0;
        end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = '{v && !(st || br), we, ld, rd};
            if (st && m_sc < SAT) m_sc++;
            if (br && m_fc < SAT) m_fc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic op(input int rd, input int rs1, input int rs2, input bit re1, input bit re2,
                      input bit we, input bit ld, input bit br);
        drive(0, 1, rd, rs1, rs2, re1, re2, we, ld, br);
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", n, a, x, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                if (e.chk) begin
                    cmp("fwd_a", 32'(fwd_a), 32'(e.fa));
                    cmp("fwd_b", 32'(fwd_b), 32'(e.fb));
                    cmp("stall_if", 32'(stall_if), 32'(e.sif));
                    cmp("stall_id", 32'(stall_id), 32'(e.sid));
                    cmp("flush_id", 32'(flush_id), 32'(e.fid));
                    cmp("flush_ex", 32'(flush_ex), 32'(e.fex));
                    cmp("stall_cnt", 32'(stall_cnt), 32'(e.sc));
                    cmp("flush_cnt", 32'(flush_cnt), 32'(e.fc));
                end
            end
        end
    end

    initial begin
        for (int a = 0; a < 3; a++) hist[a] = '{0, 0, 0, 0};
        rst = 1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_re1 = 0; id_re2 = 0;
        id_rd = 0; id_rf_we = 0; id_is_load = 0; ex_br_taken = 0;
        @(posedge clk);
        #1;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        op(3, 3, 3, 1, 1, 1, 1, 0);
        op(6, 3, 1, 1, 1, 1, 0, 0);
        nop(); nop(); nop();
        op(5, 0, 0, 0, 0, 1, 1, 0);
        op(6, 5, 1, 1, 1, 1, 0, 0);
        op(6, 5, 1, 1, 1, 1, 0, 0);
        nop(); nop(); nop();
        op(5, 0, 0, 0, 0, 1, 0, 0);
        op(7, 5, 5, 1, 1, 1, 0, 0);
        op(5, 0, 0, 0, 0, 1, 0, 0);
        op(12, 1, 2, 1, 1, 1, 0, 0);
        op(13, 1, 2, 1, 1, 1, 0, 0);
        op(7, 5, 5, 1, 1, 1, 0, 0);
        op(9, 0, 0, 0, 0, 1, 0, 0);
        op(9, 0, 0, 0, 0, 1, 0, 0);
        op(9, 0, 0, 0, 0, 1, 0, 0);
        op(10, 9, 9, 1, 1, 1, 0, 0);
        op(0, 1, 0, 1, 0, 1, 1, 0);
        op(11, 0, 0, 1, 1, 1, 0, 0);
        nop(); nop(); nop();
        op(5, 0, 0, 0, 0, 1, 1, 0);
        op(6, 5, 1, 1, 1, 1, 0, 1);
        op(4, 6, 5, 1, 1, 1, 0, 0);
        repeat (20) begin
            op(5, 0, 0, 0, 0, 1, 1, 0);
            op(6, 1, 5, 0, 1, 1, 0, 0);
        end
        op(5, 0, 0, 0, 0, 1, 1, 0);
        drive(1, 1, 6, 5, 5, 1, 1, 1, 0, 1);
        op(6, 5, 5, 1, 1, 1, 0, 0);
        op(7, 6, 5, 1, 1, 1, 0, 0);
        repeat (1500)
            drive($urandom_range(63) == 0, $urandom_range(3) != 0, $urandom_range(3),
                  $urandom_range(3), $urandom_range(3), 1'($urandom), 1'($urandom),
                  1'($urandom), $urandom_range(2) == 0, $urandom_range(7) == 0);
        @(negedge clk);
        cmp("sb_empty", 32'(sbq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, 32, width of the stall and flush performance counters.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 id_valid  input  1  ID stage holds a real instruction.
REQ-005 id_rs1 / id_rs2  input  5 each  ID source register indices.
REQ-006 id_re1 / id_re2  input  1 each  ID instruction reads rs1 / rs2.
REQ-007 id_rd  input  5  ID destination index.
REQ-008 id_rf_we  input  1  ID instruction writes the register file (rf_we from the decoder).
REQ-009 id_is_load  input  1  ID instruction is a load (rf_wsel selects read data).
REQ-010 ex_br_taken  input  1  EX-stage branch taken or jump (JAL/JALR) redirect.
REQ-011 stall_if  output  1  hold the PC.
REQ-012 stall_id  output  1  hold the IF/ID register.
REQ-013 flush_id  output  1  load a bubble into IF/ID.
REQ-014 flush_ex  output  1  load a bubble into ID/EX.
REQ-015 fwd_a / fwd_b  output  2 each  ID operand source: 00 regfile, 01 EX result, 10 MEM result, 11 WB result.
REQ-016 stall_cnt / flush_cnt  output  CNT_W each  performance counters.

Function
REQ-017 The block SHALL keep three shadow slots (EX, MEM, WB), each {valid, rd, we, load}, that mirror the datapath pipeline.
REQ-018 Each cycle: WB <= MEM and MEM <= EX unconditionally.
REQ-019 EX SHALL load {id_valid, id_rd, id_rf_we, id_is_load} unless flush_ex is 1, in which case EX.valid SHALL become 0.
REQ-020 Slot "hits" rs: slot.valid & slot.we & slot.rd != 0 & slot.rd == rs & matching re bit & id_valid.
REQ-021 Load-use: load_use = EX hits rs1 or rs2 with EX.load = 1; combinational, same cycle.
REQ-022 When load_use = 1 and ex_br_taken = 0: stall_if = stall_id = flush_ex = 1 and flush_id = 0; exactly one bubble is inserted, because the load advances to MEM on the next cycle.
REQ-023 When ex_br_taken = 1: flush_id = flush_ex = 1 and stall_if = stall_id = 0, regardless of load_use (redirect wins).
REQ-024 Otherwise all four stall/flush outputs SHALL be 0.
REQ-025 fwd_a / fwd_b SHALL be combinational with priority EX (01) > MEM (10) > WB (11) > regfile (00), evaluated per operand using that operand's rs and re.
REQ-026 An EX hit with EX.load = 1 SHALL NOT select 01; the next-priority source SHALL be used instead (the stall covers the hazard).
REQ-027 A MEM hit by a load SHALL select 10 (load data is available at the MEM output).
REQ-028 rd = 0 SHALL never produce a hit, forwarding or stall.
REQ-029 Both operands hitting different slots SHALL be resolved independently.
REQ-030 stall_cnt SHALL increment by 1 in each cycle in which REQ-022 applies; flush_cnt SHALL increment by 1 in each cycle with ex_br_taken = 1.
REQ-031 Both counters SHALL saturate at all-ones.
REQ-032 Outputs SHALL have no dependence on clk other than through the slot and counter registers; there are no extra latency stages.

Reset
REQ-033 On rst = 1 at a rising edge, all slot valid bits and both counters SHALL be cleared; slot rd/we/load fields SHALL be cleared to 0.
REQ-034 While rst = 1, the datapath flush outputs are don't-care, but the slots SHALL remain cleared.
REQ-035 In the first cycle after reset, stall/flush = 0 and fwd = 00 for any ID inputs.
REQ-036 Reset asserted mid-stall or mid-flush SHALL abandon it with no residual bubble or count.

Verification
REQ-037 Load x5 then add x6,x5,x1 in consecutive cycles -> one cycle of stall_if = stall_id = flush_ex = 1; next cycle fwd_a = 10; stall_cnt = 1.
REQ-038 addi x5, then or x7,x5,x5 next cycle -> fwd_a = fwd_b = 01, no stall; with two independent instructions between -> fwd = 11.
REQ-039 Three back-to-back writers of x9, then a reader of x9 -> fwd = 01 (EX priority); writer to x0, then a reader of x0 -> fwd = 00, no stall.
REQ-040 ex_br_taken = 1 in the same cycle as a load_use condition -> flush_id = flush_ex = 1, stall = 0; flush_cnt +1, stall_cnt unchanged.
REQ-041 Preload stall_cnt near all-ones via repeated load-use -> it holds at all-ones; rst pulse during a stall -> counters = 0, outputs idle next cycle.
